// File: rtl/mmio_timer_pwm_pkg.sv
// mmio_timer_pwm_pkg: shared definitions for the MMIO timer/PWM block.
//   - byte offsets of the registers inside the 256-byte window
//   - CTRL bit positions
//   - access-size encoding carried on funct3[1:0]
//   - lane_merge(): folds a byte/half/word store into an existing word
package mmio_timer_pwm_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_MICROS = 8'h08;
  localparam logic [7:0] OFF_MILLIS = 8'h0C;
  localparam logic [7:0] OFF_CMP    = 8'h10;
  localparam logic [7:0] OFF_RELOAD = 8'h14;
  localparam logic [7:0] OFF_DUTY0  = 8'h20;

  localparam int unsigned CTRL_PWM_EN = 0;
  localparam int unsigned CTRL_TMR_EN = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Byte goes to lane addr[1:0]; half goes to lanes {1,0} or {3,2} by addr[1].
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input size_e       size,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: w[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mmio_timer_pwm_channel.sv
// pwm_channel: one PWM output with double-buffered duty.
//   i_clk, i_rst      clock, async active-high reset
//   i_wr, i_wdata     CPU write into the duty shadow register
//   i_cnt, i_pwm_en   shared period counter and global enable
//   o_shadow          shadow duty for read-back
//   o_pwm             registered output, polarity set by ACTIVE_LOW
module pwm_channel
  import mmio_timer_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr,
  input  logic [PWM_BITS-1:0] i_wdata,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic                i_pwm_en,
  output logic [PWM_BITS-1:0] o_shadow,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_active;
  logic                r_out;
  logic                w_load;

  // Active duty follows the shadow only at the period boundary, or freely while idle.
  assign w_load = ~i_pwm_en | (i_cnt == '1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_out    <= ACTIVE_LOW;
    end else begin
      if (i_wr)   r_shadow <= i_wdata;
      if (w_load) r_active <= r_shadow;
      r_out <= (i_pwm_en && (i_cnt < r_active)) ? ~ACTIVE_LOW : ACTIVE_LOW;
    end
  end

  assign o_shadow = r_shadow;
  assign o_pwm    = r_out;

endmodule

// File: rtl/mmio_timer_pwm.sv
// mmio_timer_pwm: memory-mapped micros/millis time base, compare timer with
// auto-reload and sticky interrupt, and PWM_CHANNELS double-buffered PWM outputs.
//   clk, reset   clock, async active-high reset
//   funct3       access size on [1:0] (byte/half/word)
//   wren         write strobe (qualified by window hit)
//   address      byte address; window = BASE_ADDR[31:8]
//   data_in      write data
//   data_out     registered read data (0 when no hit)
//   hit          registered window hit of the previous address
//   pwm_out      PWM outputs
//   irq          pending & irq_en
module mmio_timer_pwm
  import mmio_timer_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFFFF00,
  parameter int unsigned CLK_FREQ     = 12000000,
  parameter int unsigned PWM_CHANNELS = 4,
  parameter int unsigned PWM_BITS     = 8,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              funct3,
  input  logic                    wren,
  input  logic [31:0]             address,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  output logic                    hit,
  output logic [PWM_CHANNELS-1:0] pwm_out,
  output logic                    irq
);

  if ((CLK_FREQ == 0) || ((CLK_FREQ % 1000000) != 0)) begin : g_bad_clk
    $error("CLK_FREQ must be a non-zero multiple of 1000000");
  end
  if (BASE_ADDR[7:0] != 8'h00) begin : g_bad_base
    $error("BASE_ADDR must be 256-byte aligned");
  end
  if ((PWM_CHANNELS < 1) || (PWM_CHANNELS > 8)) begin : g_bad_ch
    $error("PWM_CHANNELS must be 1..8");
  end
  if ((PWM_BITS < 2) || (PWM_BITS > 16)) begin : g_bad_bits
    $error("PWM_BITS must be 2..16");
  end

  localparam logic [31:0] PRESC_MAX = 32'(CLK_FREQ / 1000000 - 1);

  logic [2:0]          r_ctrl;
  logic                r_pending;
  logic [31:0]         r_presc;
  logic [9:0]          r_sub;
  logic [31:0]         r_micros;
  logic [31:0]         r_millis;
  logic [31:0]         r_cmp;
  logic [31:0]         r_reload;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  logic                w_sel;
  logic [7:0]          w_off;
  size_e               w_sz;
  logic                w_we;
  logic                w_lane0;
  logic [31:0]         w_rdata;
  logic [31:0]         w_wdata;
  logic                w_us_tick;
  logic [31:0]         w_us_next;
  logic                w_cmp_hit;
  logic [PWM_BITS-1:0] w_shadow [PWM_CHANNELS];
  logic                w_unused;

  assign w_sel    = (address[31:8] == BASE_ADDR[31:8]);
  assign w_off    = {address[7:2], 2'b00};
  assign w_sz     = size_e'(funct3[1:0]);
  assign w_we     = wren & w_sel;
  assign w_unused = funct3[2];

  // STATUS is W1C, so only the store lane that actually carries bit 0 may clear it.
  assign w_lane0 = (w_sz != SZ_BYTE && w_sz != SZ_HALF) ||
                   (w_sz == SZ_BYTE && address[1:0] == 2'b00) ||
                   (w_sz == SZ_HALF && !address[1]);

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = {29'd0, r_ctrl};
      OFF_STATUS: w_rdata = {31'd0, r_pending};
      OFF_MICROS: w_rdata = r_micros;
      OFF_MILLIS: w_rdata = r_millis;
      OFF_CMP:    w_rdata = r_cmp;
      OFF_RELOAD: w_rdata = r_reload;
      default: begin
        for (int unsigned i = 0; i < PWM_CHANNELS; i++) begin
          if (w_off == OFF_DUTY0 + 8'(4 * i)) w_rdata = 32'(w_shadow[i]);
        end
      end
    endcase
  end

  // Sub-word stores merge into the current register content.
  assign w_wdata = lane_merge(w_rdata, data_in, w_sz, address[1:0]);

  assign w_us_tick = (r_presc == PRESC_MAX);
  assign w_us_next = r_micros + 32'd1;
  assign w_cmp_hit = w_us_tick & r_ctrl[CTRL_TMR_EN] & (w_us_next == r_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_pending <= 1'b0;
      r_presc   <= '0;
      r_sub     <= '0;
      r_micros  <= '0;
      r_millis  <= '0;
      r_cmp     <= '0;
      r_reload  <= '0;
      r_pwm_cnt <= '0;
      data_out  <= '0;
      hit       <= 1'b0;
    end else begin
      r_presc <= w_us_tick ? '0 : r_presc + 32'd1;
      if (w_us_tick) begin
        r_micros <= w_us_next;
        r_sub    <= (r_sub == 10'd999) ? '0 : r_sub + 10'd1;
        if (r_sub == 10'd999) r_millis <= r_millis + 32'd1;
      end

      if (w_we && w_off == OFF_CTRL) r_ctrl <= w_wdata[2:0];

      if (w_cmp_hit)
        r_pending <= 1'b1;
      else if (w_we && w_off == OFF_STATUS && w_lane0 && data_in[0])
        r_pending <= 1'b0;

      // A CPU store to CMP overrides the reload add on a coincident hit.
      if (w_we && w_off == OFF_CMP)
        r_cmp <= w_wdata;
      else if (w_cmp_hit && r_reload != '0)
        r_cmp <= r_cmp + r_reload;

      if (w_we && w_off == OFF_RELOAD) r_reload <= w_wdata;

      r_pwm_cnt <= r_ctrl[CTRL_PWM_EN] ? r_pwm_cnt + 1'b1 : '0;

      data_out <= w_sel ? w_rdata : '0;
      hit      <= w_sel;
    end
  end

  for (genvar g = 0; g < PWM_CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_wr    (w_we && (w_off == OFF_DUTY0 + 8'(4 * g))),
      .i_wdata (w_wdata[PWM_BITS-1:0]),
      .i_cnt   (r_pwm_cnt),
      .i_pwm_en(r_ctrl[CTRL_PWM_EN]),
      .o_shadow(w_shadow[g]),
      .o_pwm   (pwm_out[g])
    );
  end

  assign irq = r_pending & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer_pwm.sv
module tb_mmio_timer_pwm;
  import mmio_timer_pwm_pkg::*;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'hFFFFFF00;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [2:0]     funct3 = 3'b010;
  logic           wren = 1'b0;
  logic [31:0]    address = '0;
  logic [31:0]    data_in = '0;
  logic [31:0]    data_out;
  logic           hit;
  logic [NCH-1:0] pwm_out;
  logic           irq;

  mmio_timer_pwm #(
    .BASE_ADDR   (BASE),
    .CLK_FREQ    (12000000),
    .PWM_CHANNELS(NCH),
    .PWM_BITS    (8),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .funct3  (funct3),
    .wren    (wren),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .hit     (hit),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release: the reference time base.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] mbytes [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sync_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) check("sync", cyc, target);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h, output int k);
    address = a;
    wren    = 1'b0;
    funct3  = 3'b010;
    k       = cyc;
    @(posedge clk);
    #1;
    d = data_out;
    h = hit;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    logic [7:0] b;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    b = a[7:0] & ~8'(n - 1);
    for (int i = 0; i < n; i++) mbytes[b + i] = d[8*i +: 8];
    address = a;
    data_in = d;
    funct3  = {1'b0, sz};
    wren    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  function automatic logic [31:0] mword(input logic [7:0] off);
    return {mbytes[off + 3], mbytes[off + 2], mbytes[off + 1], mbytes[off]};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, x;
    logic        h;
    int          k, c, r, d1, d2, d3, e0, g;
    int          act [NCH][3];
    int          lead[NCH][3];
    int          expd[NCH][3];
    bit          run [NCH];
    logic [7:0]  off;
    logic [1:0]  sz;

    for (int i = 0; i < 256; i++) mbytes[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_pwm", 32'(pwm_out), 32'hF);
    check("rst_irq", 32'(irq), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_dout", data_out, 0);
    rd(BASE | 32'(OFF_CTRL), d, h, k);   check("rst_ctrl", d, 0);
    rd(BASE | 32'(OFF_STATUS), d, h, k); check("rst_status", d, 0);
    rd(BASE | 32'(OFF_CMP), d, h, k);    check("rst_cmp", d, 0);
    rd(BASE | 32'(OFF_DUTY0), d, h, k);  check("rst_duty0", d, 0);
    check("rd_hit", 32'(h), 1);

    // Compare timer: hits at micros c, c+r, c+2r; micros m is reached at edge 12*m
    c = $urandom_range(40, 60);
    r = $urandom_range(80, 120);
    wr(BASE | 32'(OFF_CMP), 32'(c), SZ_WORD);
    wr(BASE | 32'(OFF_RELOAD), 32'(r), SZ_WORD);
    wr(BASE | 32'(OFF_CTRL), 32'h6, SZ_WORD);
    sync_to(12 * c - 1);
    check("irq_before_hit1", 32'(irq), 0);
    @(negedge clk);
    check("irq_hit1", 32'(irq), 1);
    rd(BASE | 32'(OFF_STATUS), d, h, k); check("status_hit1", d, 1);
    rd(BASE | 32'(OFF_CMP), d, h, k);    check("cmp_reload1", d, 32'(c + r));
    wr(BASE | 32'(OFF_STATUS), 32'h1, SZ_WORD);
    check("irq_w1c", 32'(irq), 0);
    sync_to(12 * (c + r) - 1);
    check("irq_before_hit2", 32'(irq), 0);
    wr(BASE | 32'(OFF_STATUS), 32'h1, SZ_WORD);
    check("irq_hit2_vs_w1c", 32'(irq), 1);
    rd(BASE | 32'(OFF_CMP), d, h, k);    check("cmp_reload2", d, 32'(c + 2 * r));
    wr(BASE | 32'(OFF_STATUS), 32'h1, SZ_WORD);
    sync_to(12 * (c + 2 * r) - 1);
    check("irq_before_hit3", 32'(irq), 0);
    @(negedge clk);
    check("irq_hit3", 32'(irq), 1);

    // Time base against elapsed cycles
    for (int i = 0; i < 4; i++) begin
      sync_to(cyc + $urandom_range(300, 1500));
      rd(BASE | 32'(OFF_MICROS), d, h, k); check("micros", d, 32'(k / 12));
      rd(BASE | 32'(OFF_MILLIS), d, h, k); check("millis", d, 32'(k / 12000));
    end
    sync_to(12000);
    rd(BASE | 32'(OFF_MICROS), d, h, k); check("micros_12000", d, 32'd1000);
    sync_to(12000 + $urandom_range(0, 600));
    rd(BASE | 32'(OFF_MILLIS), d, h, k); check("millis_1", d, 32'(k / 12000));

    // PWM: per period, count active samples and the leading active run
    d1 = $urandom_range(1, 254);
    do d2 = $urandom_range(1, 254); while (d2 == d1);
    d3 = $urandom_range(0, 255);
    wr(BASE | 32'(OFF_DUTY0),      32'(d1), SZ_WORD);
    wr(BASE | 32'(OFF_DUTY0 + 4),  32'd0,   SZ_WORD);
    wr(BASE | 32'(OFF_DUTY0 + 8),  32'd255, SZ_WORD);
    wr(BASE | 32'(OFF_DUTY0 + 12), 32'(d3), SZ_WORD);
    e0 = cyc + 1;
    wr(BASE | 32'(OFF_CTRL), 32'h1, SZ_WORD);
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < 3; p++) begin
        act[ch][p] = 0; lead[ch][p] = 0;
      end
    for (int p = 0; p < 3; p++) begin
      expd[0][p] = (p < 2) ? d1 : d2;
      expd[1][p] = 0;
      expd[2][p] = 255;
      expd[3][p] = d3;
    end
    sync_to(e0 + 1);
    fork
      begin
        for (int s = 0; s < 768; s++) begin
          if (s % 256 == 0) for (int ch = 0; ch < NCH; ch++) run[ch] = 1'b1;
          for (int ch = 0; ch < NCH; ch++) begin
            if (pwm_out[ch] == 1'b0) begin
              act[ch][s / 256]++;
              if (run[ch]) lead[ch][s / 256]++;
            end else begin
              run[ch] = 1'b0;
            end
          end
          if (s != 767) @(negedge clk);
        end
      end
      begin
        sync_to(e0 + 356);
        wr(BASE | 32'(OFF_DUTY0), 32'(d2), SZ_WORD);
      end
    join
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < 3; p++) begin
        check($sformatf("pwm_cnt_ch%0d_p%0d", ch, p), 32'(act[ch][p]), 32'(expd[ch][p]));
        check($sformatf("pwm_lead_ch%0d_p%0d", ch, p), 32'(lead[ch][p]), 32'(expd[ch][p]));
      end

    // Async reset mid-period
    wr(BASE | 32'(OFF_CTRL), 32'h5, SZ_WORD);
    check("irq_en_pending", 32'(irq), 1);
    g = 0;
    while (pwm_out[2] != 1'b0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("ch2_active_pre_rst", 32'(pwm_out[2]), 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'hF);
    check("async_rst_irq", 32'(irq), 0);
    check("async_rst_hit", 32'(hit), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mbytes[i] = '0;

    // Sub-word stores into CMP/RELOAD against a byte-array model
    wr(BASE | 32'h15, 32'hDEADBEAB, SZ_BYTE);
    rd(BASE | 32'(OFF_RELOAD), d, h, k); check("sb_reload", d, mword(OFF_RELOAD));
    wr(BASE | 32'h12, 32'hCAFE1234, SZ_HALF);
    rd(BASE | 32'(OFF_CMP), d, h, k);    check("sh_cmp", d, mword(OFF_CMP));
    repeat (6) begin
      off = 8'($urandom_range(16, 23));
      sz  = 2'($urandom_range(0, 2));
      if (sz == 2'b01) off[0] = 1'b0;
      if (sz == 2'b10) off[1:0] = 2'b00;
      wr(BASE | 32'(off), $urandom, sz);
    end
    rd(BASE | 32'(OFF_CMP), d, h, k);    check("rand_cmp", d, mword(OFF_CMP));
    rd(BASE | 32'(OFF_RELOAD), d, h, k); check("rand_reload", d, mword(OFF_RELOAD));

    // Unmapped, masked and out-of-window reads
    rd(BASE | 32'h18, d, h, k);
    check("unmapped_data", d, 0);
    check("unmapped_hit", 32'(h), 1);
    x = $urandom;
    wr(BASE | 32'(OFF_CTRL), x, SZ_WORD);
    rd(BASE | 32'(OFF_CTRL), d, h, k);   check("ctrl_mask", d, x & 32'h7);
    wr(BASE | 32'(OFF_CTRL), 32'h0, SZ_WORD);
    x = $urandom;
    wr(BASE | 32'(OFF_DUTY0 + 8), x, SZ_WORD);
    rd(BASE | 32'(OFF_DUTY0 + 8), d, h, k); check("duty_mask", d, x & 32'hFF);
    rd(32'h12345610, d, h, k);
    check("miss_data", d, 0);
    check("miss_hit", 32'(h), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
